// File: rtl/button_pio_db_pkg.sv
// Shared constants for the debounced button PIO: register word addresses and
// the reset debounce limit.
package button_pio_db_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RAW      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
  localparam logic [2:0] ADDR_DB_LIMIT = 3'd6;

  // 10 ms at 50 MHz
  localparam int DB_DEFAULT_C = 500000;
endpackage

// File: rtl/button_pio_db_chan.sv
// One input bit: synchroniser, debounce counter, debounced state and
// single-cycle rise/fall strobes.
module button_db_chan #(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CNT_W    = 20,
  parameter logic IDLE        = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_raw,
  input  logic [DB_CNT_W-1:0] i_leff,
  input  logic                i_cnt_clr,
  output logic                o_sync,
  output logic                o_db,
  output logic                o_rise,
  output logic                o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_CNT_W-1:0]    r_cnt;
  logic                   r_db, r_db_q;
  logic [DB_CNT_W:0]      w_cnt_inc;
  logic                   w_sync;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  // one extra bit so cnt+1 cannot wrap past a full-scale limit
  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= {SYNC_STAGES{IDLE}};
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_db   <= IDLE;
      r_db_q <= IDLE;
    end else begin
      r_db_q <= r_db;
      if (i_cnt_clr || w_sync == r_db) begin
        r_cnt <= '0;
      end else if (w_cnt_inc >= {1'b0, i_leff}) begin
        r_db  <= w_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_inc[DB_CNT_W-1:0];
      end
    end
  end

  assign o_sync = w_sync;
  assign o_db   = r_db;
  assign o_rise = r_db & ~r_db_q;
  assign o_fall = ~r_db & r_db_q;
endmodule

// File: rtl/button_pio_db.sv
// Debounced multi-bit button PIO with per-bit edge capture and a level irq,
// exposed as an Avalon-MM slave with registered read data.
module button_pio_db
  import button_pio_db_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               DB_CNT_W    = 20,
  parameter int               DB_DEFAULT  = DB_DEFAULT_C,
  parameter logic [WIDTH-1:0] IDLE_LEVEL  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam logic [DB_CNT_W-1:0] DB_RST = DB_CNT_W'(DB_DEFAULT);

  logic [WIDTH-1:0]    r_mask, r_cap, r_rise_en, r_fall_en;
  logic [DB_CNT_W-1:0] r_db_limit;
  logic [31:0]         r_readdata;

  logic [WIDTH-1:0]    w_sync, w_db, w_rise, w_fall, w_event, w_clr;
  logic [DB_CNT_W-1:0] w_leff;
  logic                w_wr, w_lim_wr;
  logic [31:0]         w_rd_mux;
  logic                w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_lim_wr = w_wr && (address == ADDR_DB_LIMIT);
  assign w_leff   = (r_db_limit == '0) ? DB_CNT_W'(1) : r_db_limit;
  assign w_unused = &{1'b0, writedata};

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    button_db_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CNT_W   (DB_CNT_W),
      .IDLE       (IDLE_LEVEL[g])
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_raw    (in_port[g]),
      .i_leff   (w_leff),
      .i_cnt_clr(w_lim_wr),
      .o_sync   (w_sync[g]),
      .o_db     (w_db[g]),
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g])
    );
  end

  assign w_event = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_clr   = (w_wr && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask     <= '0;
      r_cap      <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '1;
      r_db_limit <= DB_RST;
    end else begin
      // a new event outranks a same-cycle W1C on that bit
      r_cap <= (r_cap & ~w_clr) | w_event;
      if (w_wr) begin
        case (address)
          ADDR_IRQ_MASK: r_mask     <= writedata[WIDTH-1:0];
          ADDR_RISE_EN:  r_rise_en  <= writedata[WIDTH-1:0];
          ADDR_FALL_EN:  r_fall_en  <= writedata[WIDTH-1:0];
          ADDR_DB_LIMIT: r_db_limit <= writedata[DB_CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:     w_rd_mux[WIDTH-1:0]    = w_db;
      ADDR_RAW:      w_rd_mux[WIDTH-1:0]    = w_sync;
      ADDR_IRQ_MASK: w_rd_mux[WIDTH-1:0]    = r_mask;
      ADDR_EDGE_CAP: w_rd_mux[WIDTH-1:0]    = r_cap;
      ADDR_RISE_EN:  w_rd_mux[WIDTH-1:0]    = r_rise_en;
      ADDR_FALL_EN:  w_rd_mux[WIDTH-1:0]    = r_fall_en;
      ADDR_DB_LIMIT: w_rd_mux[DB_CNT_W-1:0] = r_db_limit;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;
  assign irq      = |(r_cap & r_mask);
endmodule

// File: tb/tb_button_pio_db.sv
// Self-checking bench for button_pio_db: register-read vector table plus
// hand-written debounce, edge-select, W1C race and reset sequences.
module tb_button_pio_db;
  localparam int WIDTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [WIDTH-1:0] in_port = 4'hF;
  logic        irq;

  always #5 clk = ~clk;

  button_pio_db #(
    .WIDTH(WIDTH), .SYNC_STAGES(2), .DB_CNT_W(20), .DB_DEFAULT(500000),
    .IDLE_LEVEL(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  typedef struct { logic [2:0] addr; logic [31:0] exp; } rd_vec_t;
  typedef struct { string name; logic [31:0] exp; } sb_t;

  rd_vec_t rst_tab[8];
  sb_t     sb_q[$];
  int      checks = 0;
  int      failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // expected value is queued when the read is issued, compared when data returns
  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    chipselect = 1'b1; write_n = 1'b1; address = a;
    e.name = name; e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk); #1;
    chipselect = 1'b0;
    e = sb_q.pop_front();
    check(e.name, readdata, e.exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_reset_table(input string tag);
    for (int i = 0; i < 8; i++)
      rd(rst_tab[i].addr, rst_tab[i].exp, $sformatf("%s_addr%0d", tag, i));
  endtask

  initial begin
    rst_tab[0] = '{3'd0, 32'hF};
    rst_tab[1] = '{3'd1, 32'hF};
    rst_tab[2] = '{3'd2, 32'h0};
    rst_tab[3] = '{3'd3, 32'h0};
    rst_tab[4] = '{3'd4, 32'h0};
    rst_tab[5] = '{3'd5, 32'hF};
    rst_tab[6] = '{3'd6, 32'd500000};
    rst_tab[7] = '{3'd7, 32'h0};

    // reset state
    tick(3);
    check("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    tick(2);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rd_reset_table("rst");

    // press bit0: capture lands 7 edges after the edge following the step
    wr(3'd6, 32'd4);
    wr(3'd2, 32'h1);
    in_port = 4'hE;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      if (k == 6) check("press_irq_early", {31'b0, irq}, 32'h0);
      if (k == 7) check("press_irq_set", {31'b0, irq}, 32'h1);
    end
    rd(3'd0, 32'hE, "press_data");
    rd(3'd3, 32'h1, "press_cap");
    wr(3'd3, 32'h1);
    check("w1c_irq_clear", {31'b0, irq}, 32'h0);

    // 3-cycle glitch on bit1 is filtered out
    in_port = 4'hC;
    tick(3);
    in_port = 4'hE;
    tick(10);
    rd(3'd0, 32'hE, "glitch_data");
    rd(3'd3, 32'h0, "glitch_cap");
    in_port = 4'hF;
    tick(10);
    rd(3'd0, 32'hF, "release0_data");
    rd(3'd3, 32'h0, "release0_cap");

    // edge selection on bit2
    wr(3'd4, 32'h4);
    wr(3'd5, 32'h0);
    in_port = 4'hB; tick(10);
    rd(3'd3, 32'h0, "rise_only_press");
    in_port = 4'hF; tick(10);
    rd(3'd3, 32'h4, "rise_only_release");
    wr(3'd3, 32'h4);
    wr(3'd5, 32'h4);
    in_port = 4'hB; tick(10);
    rd(3'd3, 32'h4, "both_press");
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h0, "both_cleared");
    in_port = 4'hF; tick(10);
    rd(3'd3, 32'h4, "both_release");
    wr(3'd3, 32'h4);

    // W1C partial clear, then W1C racing a new event
    wr(3'd4, 32'h0);
    wr(3'd5, 32'h3);
    in_port = 4'hC; tick(10);
    rd(3'd3, 32'h3, "cap_two_bits");
    wr(3'd3, 32'h1);
    rd(3'd3, 32'h2, "w1c_bit0");
    wr(3'd3, 32'h2);
    rd(3'd3, 32'h0, "w1c_bit1");
    wr(3'd2, 32'h2);
    check("race_irq_before", {31'b0, irq}, 32'h0);
    wr(3'd4, 32'h2);
    in_port = 4'hE;
    tick(6);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd3; writedata = 32'h2;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    check("race_irq_held", {31'b0, irq}, 32'h1);
    rd(3'd3, 32'h2, "race_cap");

    // async reset mid-debounce of bit3 (cnt at 3 of 4)
    in_port = 4'h6;
    tick(5);
    reset_n = 1'b0;
    in_port = 4'hF;
    #1;
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    check("async_rst_readdata", readdata, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(12);
    check("post_rst_irq", {31'b0, irq}, 32'h0);
    rd_reset_table("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
